// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch state type, timing constants and output decode
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      LAP     = 2'd2,
      PAUSED  = 2'd3
   } sw_state_e;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
   localparam int TICK_10MS_CYCLES        = 500000;

   function automatic logic state_run(sw_state_e s);
      return (s == RUNNING) || (s == LAP);
   endfunction

   // Lap freezes the display while the counter keeps running underneath.
   function automatic logic state_hold(sw_state_e s);
      return (s == LAP);
   endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// rtl/stopwatch_controller_if.sv - raw key inputs and counter/display control outputs
interface stopwatch_controller_if;

   logic       key_start_stop;
   logic       key_lap_reset;
   logic       run;
   logic       clear;
   logic       hold;
   logic [1:0] state;

   modport master (
      output key_start_stop, key_lap_reset,
      input  run, clear, hold, state
   );

   modport slave (
      input  key_start_stop, key_lap_reset,
      output run, clear, hold, state
   );

endinterface

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchronizer, debounce counter and press-edge pulse for one active-low key
module key_debouncer
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n_i,
   output logic press_o
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          stable_dly_q;
   logic          press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any sample that agrees with the accepted level restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         stable_q     <= 1'b1;
         stable_dly_q <= 1'b1;
         cnt_q        <= '0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= key_n_i;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         cnt_q        <= cnt_d;
         stable_dly_q <= stable_q;
         press_q      <= stable_dly_q & ~stable_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - debounced two-key Moore sequencer driving run, clear and lap hold
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                   clock,
   input  logic                   reset_n,
   stopwatch_controller_if.slave  sw
);

   logic      ss_evt, lr_evt;
   sw_state_e state_q, state_d;
   logic      clear_q, clear_d;
   logic      run_q, hold_q;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start_stop (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n_i (sw.key_start_stop),
      .press_o (ss_evt)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap_reset (
      .clock   (clock),
      .reset_n (reset_n),
      .key_n_i (sw.key_lap_reset),
      .press_o (lr_evt)
   );

   // start_stop has priority; a coincident lap_reset is dropped entirely.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      if (ss_evt) begin
         unique case (state_q)
            IDLE:    state_d = RUNNING;
            RUNNING: state_d = PAUSED;
            LAP:     state_d = PAUSED;
            PAUSED:  state_d = RUNNING;
         endcase
      end else if (lr_evt) begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
               clear_d = 1'b1;
            end
            RUNNING: state_d = LAP;
            LAP:     state_d = RUNNING;
            PAUSED: begin
               state_d = IDLE;
               clear_d = 1'b1;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
         hold_q  <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= state_run(state_d);
         hold_q  <= state_hold(state_d);
         clear_q <= clear_d;
      end
   end

   assign sw.state = state_q;
   assign sw.run   = run_q;
   assign sw.hold  = hold_q;
   assign sw.clear = clear_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - scoreboard bench for stopwatch_controller with table reference model
module tb_stopwatch_controller;

   localparam int D = 4;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   stopwatch_controller_if sw_if ();

   stopwatch_controller #(.DEBOUNCE_CYCLES(D)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sw      (sw_if)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  st;
      logic        run;
      logic        hold;
      logic        clr;
      int unsigned at;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference: state transition tables indexed by current state (IDLE,RUNNING,LAP,PAUSED)
   int m_state = 0;
   int nxt_ss [4] = '{1, 3, 3, 1};
   int nxt_lr [4] = '{0, 2, 1, 0};
   bit clr_lr [4] = '{1, 0, 0, 1};
   bit run_tab[4] = '{0, 1, 1, 0};
   bit hld_tab[4] = '{0, 0, 1, 0};

   task automatic check(string name, int act, int expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
      end
   endtask

   task automatic check_outputs(string name, int st, int run, int hold, int clr);
      check({name, ".state"}, int'(sw_if.state), st);
      check({name, ".run"},   int'(sw_if.run),   run);
      check({name, ".hold"},  int'(sw_if.hold),  hold);
      check({name, ".clear"}, int'(sw_if.clear), clr);
   endtask

   function automatic void model_event(bit ss, bit lr, int unsigned at);
      exp_t e;
      bit   cl;
      cl = 1'b0;
      if (ss) m_state = nxt_ss[m_state];
      else if (lr) begin
         cl      = clr_lr[m_state];
         m_state = nxt_lr[m_state];
      end else return;
      e.st   = 2'(m_state);
      e.run  = run_tab[m_state];
      e.hold = hld_tab[m_state];
      e.clr  = cl;
      e.at   = at;
      exp_q.push_back(e);
      if (cl) begin
         e.clr = 1'b0;
         e.at  = at + 1;
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: every change of the output bundle must match the next scoreboard entry.
   bit         mon_en = 1'b0;
   logic [4:0] prev   = '0;
   always @(negedge clock) begin
      logic [4:0] cur;
      exp_t       e;
      if (mon_en) begin
         cur = {sw_if.state, sw_if.run, sw_if.hold, sw_if.clear};
         if (cur !== prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_change: got state=%0d run=%0b hold=%0b clear=%0b expected no change at cycle %0d",
                        cur[4:3], cur[2], cur[1], cur[0], cyc);
            end else begin
               e = exp_q.pop_front();
               check("mon.state", int'(cur[4:3]), int'(e.st));
               check("mon.run",   int'(cur[2]),   int'(e.run));
               check("mon.hold",  int'(cur[1]),   int'(e.hold));
               check("mon.clear", int'(cur[0]),   int'(e.clr));
               check("mon.cycle", int'(cyc),      int'(e.at));
            end
         end
         prev = cur;
      end
   end

   // Drive keys low for L cycles from the current edge, then release and idle for G cycles.
   task automatic act(bit ss, bit lr, int L, int G);
      int unsigned c0;
      c0 = cyc;
      sw_if.key_start_stop = ss ? 1'b0 : 1'b1;
      sw_if.key_lap_reset  = lr ? 1'b0 : 1'b1;
      if (L >= D) model_event(ss, lr, c0 + 4 + D);
      repeat (L) @(posedge clock);
      #1;
      sw_if.key_start_stop = 1'b1;
      sw_if.key_lap_reset  = 1'b1;
      repeat (G) @(posedge clock);
      #1;
   endtask

   task automatic assert_reset_midclock();
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      mon_en  = 1'b0;
      #1;
      check_outputs("reset_midclock", 0, 0, 0, 0);
      check("reset_queue_drained", exp_q.size(), 0);
      exp_q.delete();
      m_state = 0;
   endtask

   localparam int G = D + 8;

   initial begin
      int kind;
      int waitc;
      sw_if.key_start_stop = 1'b1;
      sw_if.key_lap_reset  = 1'b1;
      reset_n = 1'b0;
      #1;
      check_outputs("reset_initial", 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      prev    = '0;
      mon_en  = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      check_outputs("idle_after_reset", 0, 0, 0, 0);

      act(1, 0, D + 2, G);
      check_outputs("start", 1, 1, 0, 0);
      act(1, 0, D, G);
      check_outputs("stop_min_press", 3, 0, 0, 0);
      act(1, 0, D - 1, G);
      check_outputs("short_press_ignored", 3, 0, 0, 0);

      assert_reset_midclock();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      prev    = '0;
      mon_en  = 1'b1;

      for (int i = 0; i < 5; i++) begin
         sw_if.key_start_stop = 1'b0;
         repeat (3) @(posedge clock);
         #1;
         sw_if.key_start_stop = 1'b1;
         @(posedge clock);
         #1;
      end
      repeat (G) @(posedge clock);
      #1;
      check_outputs("bounce_rejected", 0, 0, 0, 0);
      act(1, 0, 6, G);

      act(0, 1, D + 1, G);
      check_outputs("lap_enter", 2, 1, 1, 0);
      act(0, 1, D + 1, G);
      check_outputs("lap_resume", 1, 1, 0, 0);
      act(0, 1, D + 1, G);
      act(1, 0, D + 1, G);
      check_outputs("lap_to_paused", 3, 0, 0, 0);

      act(0, 1, D + 1, G);
      act(0, 1, D + 1, G);
      check_outputs("clear_in_idle", 0, 0, 0, 0);

      act(1, 0, D + 1, G);
      act(1, 1, D + 1, G);
      check_outputs("simultaneous_running", 3, 0, 0, 0);
      act(1, 1, D + 2, G);
      check_outputs("simultaneous_paused", 1, 1, 0, 0);

      @(posedge clock);
      #3;
      sw_if.key_lap_reset = 1'b0;
      reset_n = 1'b0;
      mon_en  = 1'b0;
      exp_q.delete();
      m_state = 0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      prev    = '0;
      mon_en  = 1'b1;
      model_event(0, 1, cyc + 4 + D);
      repeat (D + 2) @(posedge clock);
      #1;
      sw_if.key_lap_reset = 1'b1;
      repeat (G) @(posedge clock);
      #1;
      check_outputs("held_through_reset", 0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: act(1, 0, int'($urandom_range(D, D + 4)), G + int'($urandom_range(0, 3)));
            1: act(0, 1, int'($urandom_range(D, D + 4)), G + int'($urandom_range(0, 3)));
            2: act(1, 1, int'($urandom_range(D, D + 4)), G + int'($urandom_range(0, 3)));
            default: begin
               if ($urandom_range(0, 1) == 1) act(1, 0, int'($urandom_range(1, D - 1)), G);
               else                           act(0, 1, int'($urandom_range(1, D - 1)), G);
            end
         endcase
      end
      check("random_final_state", int'(sw_if.state), m_state);

      waitc = 0;
      while (exp_q.size() != 0 && waitc < 50) begin
         @(posedge clock);
         waitc++;
      end
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
